// File: rtl/mtr_pkg.sv
`default_nettype none
// ============================================================================
//  mtr_pkg - shared types and defaults for the mtr_drv H-bridge PWM driver
//  Rev 1.0 - initial release
// ============================================================================
package mtr_pkg;

    typedef enum logic [1:0] {
        BRAKE = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2
    } mtr_state_t;

    localparam int PWM_W_DEF    = 10;
    localparam int DEAD_CYC_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/mtr_drv_if.sv
`default_nettype none
// ============================================================================
//  mtr_drv_if - run enable, signed motor commands and bridge drive outputs
//  Rev 1.0 - initial release
// ============================================================================
interface mtr_drv_if #(
    parameter int PWM_W = 10
);
    logic                go;
    logic signed [PWM_W:0] lft_reg;
    logic signed [PWM_W:0] rht_reg;
    logic                fwd_lft;
    logic                rev_lft;
    logic                fwd_rht;
    logic                rev_rht;

    modport master (
        output go, lft_reg, rht_reg,
        input  fwd_lft, rev_lft, fwd_rht, rev_rht
    );

    modport slave (
        input  go, lft_reg, rht_reg,
        output fwd_lft, rev_lft, fwd_rht, rev_rht
    );
endinterface
`default_nettype wire

// File: rtl/mtr_chan.sv
`default_nettype none
// ============================================================================
//  mtr_chan - one H-bridge side: shadow regs, BRAKE/DEAD/RUN FSM, drive flops
//  Optional MTR_DEADTIME_EN inserts DEAD on start-up and direction reversal.
//  Rev 1.0 - initial release
// ============================================================================
module mtr_chan
    import mtr_pkg::*;
#(
    parameter int PWM_W    = PWM_W_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [PWM_W-1:0] i_cnt,
    input  wire logic             i_bnd,
    input  wire logic             i_go,
    input  wire logic [PWM_W:0]   i_cmd,
    output logic                  o_fwd,
    output logic                  o_rev
);

    localparam logic [PWM_W:0] c_ONE = {{PWM_W{1'b0}}, 1'b1};

    mtr_state_t       r_state;
    mtr_state_t       w_state_nxt;
    logic [PWM_W-1:0] r_mag;
    logic             r_dir;
    logic [PWM_W-1:0] w_mag_in;
    logic [PWM_W:0]   w_neg;
    logic             w_new_dir;
    logic             w_pwm;
    logic             w_fwd_nxt;
    logic             w_rev_nxt;
    logic             w_dead_done;

    assign w_new_dir = i_cmd[PWM_W];
    assign w_pwm     = (i_cnt < r_mag);

    // Only the most negative command overflows the negation; clamp it to full scale.
    always_comb begin
        w_neg    = (~i_cmd) + c_ONE;
        w_mag_in = i_cmd[PWM_W-1:0];
        if (i_cmd[PWM_W]) begin
            w_mag_in = w_neg[PWM_W] ? {PWM_W{1'b1}} : w_neg[PWM_W-1:0];
        end
    end

`ifdef MTR_DEADTIME_EN
    localparam int              c_DW        = $clog2(DEAD_CYC + 1);
    localparam logic [c_DW-1:0] c_DEAD_LAST = c_DW'(DEAD_CYC - 1);
    localparam logic [c_DW-1:0] c_DONE_ONE  = c_DW'(1);

    logic [c_DW-1:0] r_dead_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dead_cnt <= '0;
        end else if (r_state == DEAD) begin
            r_dead_cnt <= r_dead_cnt + c_DONE_ONE;
        end else begin
            r_dead_cnt <= '0;
        end
    end

    assign w_dead_done = (r_dead_cnt == c_DEAD_LAST);
`else
    assign w_dead_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BRAKE;
            r_mag   <= '0;
            r_dir   <= 1'b0;
            o_fwd   <= 1'b0;
            o_rev   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            o_fwd   <= w_fwd_nxt;
            o_rev   <= w_rev_nxt;
            if (i_bnd) begin
                r_mag <= w_mag_in;
                r_dir <= w_new_dir;
            end
        end
    end

    // Dropping go brakes immediately and wins over any boundary event.
    always_comb begin
        w_state_nxt = r_state;
        w_fwd_nxt   = 1'b0;
        w_rev_nxt   = 1'b0;
        if (!i_go) begin
            w_state_nxt = BRAKE;
            w_fwd_nxt   = 1'b1;
            w_rev_nxt   = 1'b1;
        end else begin
            case (r_state)
                BRAKE: begin
                    w_fwd_nxt = 1'b1;
                    w_rev_nxt = 1'b1;
                    if (i_bnd) begin
`ifdef MTR_DEADTIME_EN
                        w_state_nxt = DEAD;
`else
                        w_state_nxt = RUN;
`endif
                    end
                end
                RUN: begin
                    w_fwd_nxt = w_pwm & ~r_dir;
                    w_rev_nxt = w_pwm &  r_dir;
`ifdef MTR_DEADTIME_EN
                    if (i_bnd && (w_new_dir != r_dir)) begin
                        w_state_nxt = DEAD;
                    end
`endif
                end
                DEAD: begin
                    if (w_dead_done) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = BRAKE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
//  mtr_drv - sign-magnitude PWM drive for two H-bridges from signed commands
//  Build option: MTR_DEADTIME_EN (dead time on start-up and reversal)
//  Rev 1.0 - initial release
// ============================================================================
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int PWM_W    = PWM_W_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mtr_drv_if.slave    bus
);

    localparam logic [PWM_W-1:0] c_CNT_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [PWM_W-1:0] r_cnt;
    logic             w_bnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Last count of the period: shadows reload and FSMs may change mode here.
    assign w_bnd = &r_cnt;

    mtr_chan #(
        .PWM_W    (PWM_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .i_cnt (r_cnt),
        .i_bnd (w_bnd),
        .i_go  (bus.go),
        .i_cmd (bus.lft_reg),
        .o_fwd (bus.fwd_lft),
        .o_rev (bus.rev_lft)
    );

    mtr_chan #(
        .PWM_W    (PWM_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_rht (
        .clk   (clk),
        .rst_n (rst_n),
        .i_cnt (r_cnt),
        .i_bnd (w_bnd),
        .i_go  (bus.go),
        .i_cmd (bus.rht_reg),
        .o_fwd (bus.fwd_rht),
        .o_rev (bus.rev_rht)
    );

endmodule
`default_nettype wire
